// File: rtl/mram_serial_host.sv
// rtl/mram_serial_host.sv - serial MRAM host: latches one command, shifts address/data out, captures read word
module mram_serial_host #(
  parameter int READ_LAT = 2,
  parameter int GAP_CYC  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic        cmd_ube,
  input  logic        cmd_lbe,
  input  logic [19:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        ser_addr,
  output logic        ser_data,
  output logic [2:0]  read_write_sel,
  output logic        mram_rst,
  input  logic        ser_rd,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    RWAIT,
    CAPTURE,
    GAP
  } state_t;

  localparam logic [4:0] SHIFT_LAST = 5'd19;
  localparam logic [4:0] CAP_LAST   = 5'd15;
  localparam logic [4:0] RWAIT_LAST = (READ_LAT >= 2) ? 5'(READ_LAT - 2) : 5'd0;
  localparam logic [4:0] GAP_LAST   = 5'(GAP_CYC - 1);

  state_t      state, state_n;
  logic [4:0]  cnt, cnt_n;
  logic        capture_done;
  logic        accept;
  logic        no_enables;
  logic [19:0] addr_q;
  logic [15:0] wdata_q;
  logic        we_q, ube_q, lbe_q;
  logic [14:0] rd_sh;
  logic [15:0] rd_word;
  logic        ser_addr_n, ser_data_n;

  assign accept         = cmd_valid & cmd_ready;
  assign no_enables     = ~cmd_ube & ~cmd_lbe;
  assign rd_word        = {rd_sh, ser_rd};
  assign read_write_sel = {ube_q, lbe_q, we_q};

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    capture_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = SETUP;
          cnt_n   = 5'd0;
        end
      end
      SETUP: begin
        state_n = SHIFT;
        cnt_n   = 5'd0;
      end
      SHIFT: begin
        if (cnt == SHIFT_LAST) begin
          cnt_n = 5'd0;
          if (we_q)
            state_n = GAP;
          else if (READ_LAT == 1)
            state_n = CAPTURE;
          else
            state_n = RWAIT;
        end else begin
          cnt_n = cnt + 5'd1;
        end
      end
      RWAIT: begin
        if (cnt == RWAIT_LAST) begin
          state_n = CAPTURE;
          cnt_n   = 5'd0;
        end else begin
          cnt_n = cnt + 5'd1;
        end
      end
      CAPTURE: begin
        if (cnt == CAP_LAST) begin
          state_n      = GAP;
          cnt_n        = 5'd0;
          capture_done = 1'b1;
        end else begin
          cnt_n = cnt + 5'd1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = IDLE;
          cnt_n   = 5'd0;
        end else begin
          cnt_n = cnt + 5'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 5'd0;
      end
    endcase
  end

  // Serial outputs are registered from the next state so each bit lines up with its SHIFT cycle.
  always_comb begin
    ser_addr_n = 1'b0;
    ser_data_n = 1'b0;
    if (state_n == SHIFT) begin
      ser_addr_n = addr_q[cnt_n];
      if (we_q && cnt_n < 5'd16)
        ser_data_n = wdata_q[cnt_n[3:0]];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      mram_rst  <= 1'b1;
      ser_addr  <= 1'b0;
      ser_data  <= 1'b0;
      addr_q    <= 20'd0;
      wdata_q   <= 16'd0;
      we_q      <= 1'b0;
      ube_q     <= 1'b0;
      lbe_q     <= 1'b0;
      rd_sh     <= 15'd0;
      rd_data   <= 16'd0;
      rd_valid  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cmd_ready <= (state_n == IDLE);
      busy      <= (state_n != IDLE);
      mram_rst  <= (state_n == IDLE) || (state_n == GAP);
      ser_addr  <= ser_addr_n;
      ser_data  <= ser_data_n;
      rd_valid  <= capture_done;
      if (accept) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        we_q    <= cmd_we;
        ube_q   <= cmd_ube | no_enables;
        lbe_q   <= cmd_lbe | no_enables;
      end
      if (state == CAPTURE)
        rd_sh <= rd_word[14:0];
      if (capture_done)
        rd_data <= {ube_q ? rd_word[15:8] : 8'h00, lbe_q ? rd_word[7:0] : 8'h00};
    end
  end

endmodule

// File: tb/tb_mram_serial_host.sv
// tb/tb_mram_serial_host.sv - self-checking bench for mram_serial_host with a read-data scoreboard
module tb_mram_serial_host;

  localparam int RL = 2;
  localparam int G  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic        cmd_ube;
  logic        cmd_lbe;
  logic [19:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        ser_addr;
  logic        ser_data;
  logic [2:0]  read_write_sel;
  logic        mram_rst;
  logic        ser_rd;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        busy;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] sb_q[$];
  logic [15:0] exp_rd = 16'h0000;

  always #5 clk = ~clk;

  mram_serial_host #(.READ_LAT(RL), .GAP_CYC(G)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_ube(cmd_ube), .cmd_lbe(cmd_lbe),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .ser_addr(ser_addr),
    .ser_data(ser_data), .read_write_sel(read_write_sel), .mram_rst(mram_rst),
    .ser_rd(ser_rd), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input string name, input logic we, input logic ube, input logic lbe,
                         input logic [19:0] addr, input logic [15:0] wdata,
                         input logic [15:0] rword, input logic hold_valid, input int abort_at);
    int          n;
    int          gap_start;
    int          done;
    int          k;
    logic        none;
    logic [2:0]  e_rws;
    logic        e_addr, e_data, e_mrst, e_busy, e_ready, e_valid;
    n = 0;
    while (!cmd_ready && n < 200) begin
      tick;
      n++;
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL %s ready_wait: cmd_ready=%b required 1", name, cmd_ready);
      return;
    end
    n_pass++;
    none  = ~ube & ~lbe;
    e_rws = {ube | none, lbe | none, we};
    if (!we && abort_at < 0)
      sb_q.push_back({e_rws[2] ? rword[15:8] : 8'h00, e_rws[1] ? rword[7:0] : 8'h00});
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_ube   = ube;
    cmd_lbe   = lbe;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    gap_start = we ? 21 : 36 + RL;
    done      = gap_start + G;
    tick;
    for (int c = 0; c <= done; c++) begin
      if (c > 0) tick;
      cmd_valid = hold_valid && (c < done);
      cmd_we    = 1'($urandom);
      cmd_ube   = 1'($urandom);
      cmd_lbe   = 1'($urandom);
      cmd_addr  = 20'($urandom);
      cmd_wdata = 16'($urandom);
      if (!we && c >= 20 + RL && c < 36 + RL)
        ser_rd = rword[15 - (c - 20 - RL)];
      else
        ser_rd = 1'($urandom);
      if (c == abort_at) begin
        cmd_valid = 1'b0;
        rst = 1'b0;
        #1;
        exp_rd = 16'h0000;
        n_checks += 8;
        if (cmd_ready !== 1'b0) $display("FAIL %s abort_ready: got %b required 0", name, cmd_ready); else n_pass++;
        if (busy !== 1'b0) $display("FAIL %s abort_busy: got %b required 0", name, busy); else n_pass++;
        if (mram_rst !== 1'b1) $display("FAIL %s abort_mram_rst: got %b required 1", name, mram_rst); else n_pass++;
        if (ser_addr !== 1'b0) $display("FAIL %s abort_ser_addr: got %b required 0", name, ser_addr); else n_pass++;
        if (ser_data !== 1'b0) $display("FAIL %s abort_ser_data: got %b required 0", name, ser_data); else n_pass++;
        if (read_write_sel !== 3'b000) $display("FAIL %s abort_rws: got %b required 000", name, read_write_sel); else n_pass++;
        if (rd_data !== 16'h0000) $display("FAIL %s abort_rd_data: got %h required 0000", name, rd_data); else n_pass++;
        if (rd_valid !== 1'b0) $display("FAIL %s abort_rd_valid: got %b required 0", name, rd_valid); else n_pass++;
        for (int i = 0; i < 3; i++) begin
          tick;
          n_checks += 2;
          if (rd_valid !== 1'b0) $display("FAIL %s abort_hold_rd_valid: got %b required 0", name, rd_valid); else n_pass++;
          if (busy !== 1'b0) $display("FAIL %s abort_hold_busy: got %b required 0", name, busy); else n_pass++;
        end
        rst = 1'b1;
        tick;
        n_checks += 2;
        if (cmd_ready !== 1'b1) $display("FAIL %s release_ready: got %b required 1", name, cmd_ready); else n_pass++;
        if (rd_valid !== 1'b0) $display("FAIL %s release_rd_valid: got %b required 0", name, rd_valid); else n_pass++;
        return;
      end
      k       = c - 1;
      e_addr  = (c >= 1 && c <= 20) ? addr[k] : 1'b0;
      e_data  = (c >= 1 && c <= 16 && we) ? wdata[k] : 1'b0;
      e_mrst  = (c >= gap_start);
      e_busy  = (c < done);
      e_ready = (c == done);
      e_valid = !we && (c == gap_start);
      if (e_valid) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          $display("FAIL %s scoreboard_empty: size 0 required >0", name);
        end else begin
          n_pass++;
          exp_rd = sb_q.pop_front();
        end
      end
      n_checks += 8;
      if (ser_addr !== e_addr) $display("FAIL %s ser_addr c=%0d: got %b required %b", name, c, ser_addr, e_addr); else n_pass++;
      if (ser_data !== e_data) $display("FAIL %s ser_data c=%0d: got %b required %b", name, c, ser_data, e_data); else n_pass++;
      if (mram_rst !== e_mrst) $display("FAIL %s mram_rst c=%0d: got %b required %b", name, c, mram_rst, e_mrst); else n_pass++;
      if (busy !== e_busy) $display("FAIL %s busy c=%0d: got %b required %b", name, c, busy, e_busy); else n_pass++;
      if (cmd_ready !== e_ready) $display("FAIL %s cmd_ready c=%0d: got %b required %b", name, c, cmd_ready, e_ready); else n_pass++;
      if (read_write_sel !== e_rws) $display("FAIL %s rws c=%0d: got %b required %b", name, c, read_write_sel, e_rws); else n_pass++;
      if (rd_valid !== e_valid) $display("FAIL %s rd_valid c=%0d: got %b required %b", name, c, rd_valid, e_valid); else n_pass++;
      if (rd_data !== exp_rd) $display("FAIL %s rd_data c=%0d: got %h required %h", name, c, rd_data, exp_rd); else n_pass++;
    end
  endtask

  task automatic test_reset;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_ube   = 1'b0;
    cmd_lbe   = 1'b0;
    cmd_addr  = 20'd0;
    cmd_wdata = 16'd0;
    ser_rd    = 1'b0;
    #12;
    n_checks += 8;
    if (cmd_ready !== 1'b0) $display("FAIL reset_ready: got %b required 0", cmd_ready); else n_pass++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else n_pass++;
    if (mram_rst !== 1'b1) $display("FAIL reset_mram_rst: got %b required 1", mram_rst); else n_pass++;
    if (ser_addr !== 1'b0) $display("FAIL reset_ser_addr: got %b required 0", ser_addr); else n_pass++;
    if (ser_data !== 1'b0) $display("FAIL reset_ser_data: got %b required 0", ser_data); else n_pass++;
    if (read_write_sel !== 3'b000) $display("FAIL reset_rws: got %b required 000", read_write_sel); else n_pass++;
    if (rd_data !== 16'h0000) $display("FAIL reset_rd_data: got %h required 0000", rd_data); else n_pass++;
    if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b required 0", rd_valid); else n_pass++;
    tick;
    rst = 1'b1;
    n_checks++;
    if (cmd_ready !== 1'b0) $display("FAIL release_ready_early: got %b required 0", cmd_ready); else n_pass++;
    tick;
    n_checks += 2;
    if (cmd_ready !== 1'b1) $display("FAIL release_ready: got %b required 1", cmd_ready); else n_pass++;
    if (busy !== 1'b0) $display("FAIL release_busy: got %b required 0", busy); else n_pass++;
  endtask

  task automatic test_full_write;
    run_cmd("full_write", 1'b1, 1'b1, 1'b1, 20'h00000, 16'hAAAA, 16'h0000, 1'b0, -1);
  endtask

  task automatic test_lower_write;
    run_cmd("lower_write", 1'b1, 1'b0, 1'b1, 20'h00001, 16'h5555, 16'h0000, 1'b0, -1);
  endtask

  task automatic test_full_read;
    run_cmd("full_read", 1'b0, 1'b1, 1'b1, 20'h00000, 16'h0000, 16'hA5C3, 1'b0, -1);
  endtask

  task automatic test_upper_read;
    run_cmd("upper_read", 1'b0, 1'b1, 1'b0, 20'h00002, 16'h0000, 16'h1234, 1'b0, -1);
  endtask

  task automatic test_zero_enables_hold;
    run_cmd("zero_en_write", 1'b1, 1'b0, 1'b0, 20'hABCDE, 16'h1357, 16'h0000, 1'b1, -1);
    run_cmd("zero_en_read", 1'b0, 1'b0, 1'b0, 20'h80001, 16'h0000, 16'hC0DE, 1'b1, -1);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++)
      run_cmd("b2b", 1'($urandom), 1'($urandom), 1'($urandom), 20'($urandom),
              16'($urandom), 16'($urandom), 1'b0, -1);
  endtask

  task automatic test_abort;
    run_cmd("abort_read", 1'b0, 1'b1, 1'b1, 20'hFFFFF, 16'h0000, 16'h9999, 1'b0, 11);
    run_cmd("post_abort_read", 1'b0, 1'b0, 1'b1, 20'h00400, 16'h0000, 16'hBEEF, 1'b0, -1);
    run_cmd("post_abort_write", 1'b1, 1'b1, 1'b0, 20'h7A5A5, 16'hF00F, 16'h0000, 1'b0, -1);
  endtask

  initial begin
    test_reset;
    test_full_write;
    test_lower_write;
    test_full_read;
    test_upper_read;
    test_zero_enables_hold;
    test_back_to_back;
    test_abort;
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL scoreboard_drain: %0d left required 0", sb_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mram_serial_host.md
MRAM_SERIAL_HOST -- requirements
Module: mram_serial_host

Interface
REQ-001 Parameter READ_LAT, default 2: cycles between the last address bit and the first read-data bit on ser_rd; legal range 1-15.
REQ-002 Parameter GAP_CYC, default 2: cycles mram_rst is held high after each transaction; legal range 1-15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, synchronous deassert, active-low.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high on a rising edge.
REQ-007 cmd_we  input  1  1 = write, 0 = read.
REQ-008 cmd_ube, cmd_lbe  input  1 each  upper-byte and lower-byte enables.
REQ-009 cmd_addr  input  20  MRAM word address.
REQ-010 cmd_wdata  input  16  write data.
REQ-011 ser_addr  output  1  serial address to the MRAM interface, LSB first.
REQ-012 ser_data  output  1  serial write data to the MRAM interface, LSB first.
REQ-013 read_write_sel  output  3  {ube, lbe, we} of the active command.
REQ-014 mram_rst  output  1  active-high hold/reset to the MRAM interface.
REQ-015 ser_rd  input  1  serial read data from the MRAM interface, MSB first.
REQ-016 rd_data  output  16  captured read word.
REQ-017 rd_valid  output  1  one-cycle pulse when rd_data updates.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 FSM states: IDLE, SETUP, SHIFT, RWAIT, CAPTURE, GAP.
REQ-020 On accept, the block latches all cmd_* fields and moves IDLE->SETUP; later cmd_* changes have no effect.
REQ-021 When cmd_ube and cmd_lbe are both 0, the latched enables are forced to 11.
REQ-022 SETUP lasts 1 cycle: mram_rst=0, read_write_sel driven, ser_addr=0, ser_data=0.
REQ-023 SHIFT lasts exactly 20 cycles; in cycle k (0-19), ser_addr=addr[k].
REQ-024 During SHIFT, ser_data=wdata[k] for k<16 and 0 for k>=16 on writes, and 0 in every cycle on reads.
REQ-025 After SHIFT, writes go to GAP and reads go to RWAIT.
REQ-026 RWAIT lasts READ_LAT-1 cycles; when READ_LAT=1, the block goes directly to CAPTURE.
REQ-027 CAPTURE lasts 16 cycles; the ser_rd sample in cycle j is stored to rd_data[15-j].
REQ-028 rd_valid pulses in the cycle after the last CAPTURE sample.
REQ-029 At rd_valid, bytes whose enable is 0 read as 8'h00.
REQ-030 rd_data holds its value until the next rd_valid.
REQ-031 GAP lasts GAP_CYC cycles with mram_rst=1 and read_write_sel held, then returns to IDLE.
REQ-032 In IDLE: mram_rst=1, ser_addr=0, ser_data=0, and read_write_sel holds its last value.
REQ-033 Write latency is fixed at 1+20+GAP_CYC cycles from accept to cmd_ready.
REQ-034 Read latency is fixed at 1+20+(READ_LAT-1)+16+GAP_CYC cycles from accept to cmd_ready.
REQ-035 A 5-bit shift counter wraps to 0 on every state exit; no command is dropped or queued (no back-to-back acceptance).
REQ-036 All serial and control outputs are registered, with no combinational path from ser_rd or cmd_* to any output.

Reset
REQ-037 While rst=0, the block enters IDLE immediately with cmd_ready=0, busy=0, mram_rst=1, ser_addr=0, ser_data=0, read_write_sel=000, rd_data=0, rd_valid=0, and all counters at 0.
REQ-038 cmd_ready rises in the first cycle after rst deasserts.
REQ-039 Reset asserted mid-transaction aborts the transaction without a rd_valid pulse, and the aborted command is not replayed.

Verification
REQ-040 Full write: addr=20'h00000, wdata=16'hAAAA, ube=lbe=1 -> read_write_sel=111 for 21+GAP cycles, ser_data alternates 0,1 for 16 cycles then 0000, ser_addr=0 throughout.
REQ-041 Lower-byte write: addr=20'h00001, wdata=16'h5555, ube=0, lbe=1 -> read_write_sel=011, ser_addr=1 in SHIFT cycle 0 only, cmd_ready returns after exactly 21+GAP_CYC cycles.
REQ-042 Full read: addr=0, model returns 16'hA5C3 MSB first after READ_LAT -> rd_data=16'hA5C3, one rd_valid pulse, read_write_sel=110.
REQ-043 Upper-byte read: addr=20'h00002, model returns 16'h1234 -> rd_data=16'h1200, read_write_sel=100.
REQ-044 Both enables 0 on a write -> read_write_sel=111; cmd_valid held high during busy -> no second accept until IDLE.
REQ-045 rst pulled low at SHIFT cycle 10 of a read -> all outputs take reset values within the same cycle, no rd_valid, and a new command completes normally after release.
